instruction_fetch: RTL

//   Fetch stage directly upstream of the decode/control stage. Holds the PC and issues

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 96 +++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect, and decode handshake.
// master = fetch stage, slave = memory/decode/branch side.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word fetches under a credit limit, buffers in-order responses in a
// show-ahead FIFO toward decode, and flushes/restarts on a redirect pulse.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic          run;

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] inflight_after_rsp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Buffered plus in-flight fetches never exceed DEPTH, so a push can never overflow.
  always_comb begin
    credit_used        = {1'b0, fifo_count} + {1'b0, outstanding};
    bus.imem_req_valid = run && !bus.redirect_valid && (credit_used < DEPTH_W);
    bus.imem_req_addr  = pc;
    bus.instr_valid    = (fifo_count != '0) && !bus.redirect_valid;
    bus.instruction    = mem_data[rd_ptr];
    bus.instr_pc       = mem_pc[rd_ptr];
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    rsp_drop           = (drop_cnt != '0);
    push               = bus.imem_rsp_valid && !rsp_drop && !bus.redirect_valid;
    pop                = bus.instr_valid && bus.instr_ready;
    redirect_tgt       = {bus.redirect_pc[31:2], 2'b00};
    inflight_after_rsp = outstanding - CW'(bus.imem_rsp_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      run         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      run <= 1'b1;
      if (push) begin
        mem_data[wr_ptr] <= bus.imem_rsp_data;
        mem_pc[wr_ptr]   <= rsp_pc;
      end
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the old path and must be discarded.
        pc          <= redirect_tgt;
        rsp_pc      <= redirect_tgt;
        outstanding <= inflight_after_rsp;
        drop_cnt    <= inflight_after_rsp;
        fifo_count  <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        if (bus.imem_rsp_valid && rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
